// File: rtl/fpu_drv_pkg.sv
// fpu_drv_pkg: shared types and helpers for the FPU driver front end.
//   - FPU opcode encodings
//   - FSM state enum
//   - request struct carried through the request FIFO
//   - f_class(): {nan, inf, zero} classification of a single-precision word
package fpu_drv_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_DIV = 2'd2;
   localparam logic [1:0] OP_MUL = 2'd3;

   // Storage width of the tag field inside the FIFO; the driver's TAG_W
   // must not exceed it. Unused upper bits are zero.
   localparam int TAG_WMAX = 8;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [31:0]         a;
      logic [31:0]         b;
      logic [1:0]          op;
      logic [TAG_WMAX-1:0] tag;
   } fpu_req_t;

   function automatic logic [2:0] f_class(input logic [31:0] v);
      logic exp_ones, exp_zero, man_zero;
      exp_ones = (v[30:23] == 8'hFF);
      exp_zero = (v[30:23] == 8'h00);
      man_zero = (v[22:0]  == 23'd0);
      return {exp_ones && !man_zero, exp_ones && man_zero, exp_zero && man_zero};
   endfunction

endpackage

// File: rtl/fpu_driver_if.sv
// fpu_driver_if: request stream, response stream and FPU-side signals of
// the FPU driver.
//   slave  : the driver (accepts requests, drives FPU, returns responses)
//   master : the request source / response consumer / FPU model
// Optional macro FPU_DRV_CLASS_EN adds rsp_class[2:0] = {nan, inf, zero}.
interface fpu_driver_if #(parameter int TAG_W = 4);
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [1:0]       req_op;
   logic [TAG_W-1:0] req_tag;

   logic [31:0]      fpu_a;
   logic [31:0]      fpu_b;
   logic [1:0]       fpu_opcode;
   logic [31:0]      fpu_outp;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [1:0]       rsp_op;
   logic [TAG_W-1:0] rsp_tag;
`ifdef FPU_DRV_CLASS_EN
   logic [2:0]       rsp_class;
`endif

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag,
      output req_ready,
      output fpu_a, fpu_b, fpu_opcode,
      input  fpu_outp,
      input  rsp_ready,
`ifdef FPU_DRV_CLASS_EN
      output rsp_class,
`endif
      output rsp_valid, rsp_data, rsp_op, rsp_tag
   );

   modport master (
      output req_valid, req_a, req_b, req_op, req_tag,
      input  req_ready,
      input  fpu_a, fpu_b, fpu_opcode,
      output fpu_outp,
      output rsp_ready,
`ifdef FPU_DRV_CLASS_EN
      input  rsp_class,
`endif
      input  rsp_valid, rsp_data, rsp_op, rsp_tag
   );
endinterface

// File: rtl/fpu_drv_fifo.sv
// fpu_drv_fifo: synchronous FIFO, DEPTH entries (power of 2, >= 2), W bits.
//   i_push/i_din : write (ignored when full)
//   i_pop        : read-advance (ignored when empty)
//   o_dout       : head entry, valid while !o_empty
//   o_full/o_empty/o_count : registered occupancy status
module fpu_drv_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   output logic [W-1:0]           o_dout,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_count;
   logic          w_push, w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage needs no reset; only pointers and occupancy are state.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

   // Pointers wrap naturally at AW bits because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/fpu_driver.sv
// fpu_driver: initiator-side front end for the single-precision FPU.
// Requests are queued in a FIFO, issued one at a time onto the FPU inputs,
// held for LAT edges, and the FPU result is returned on a valid/ready
// response stream in request order.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fpu_driver_if.slave (req_*, fpu_*, rsp_*)
//   busy       : FSM not IDLE or FIFO not empty
//   count      : FIFO occupancy
// Optional macro FPU_DRV_CLASS_EN: registered rsp_class = {nan, inf, zero}.
import fpu_drv_pkg::*;

module fpu_driver #(
   parameter int DEPTH = 4,
   parameter int LAT   = 1,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fpu_driver_if.slave            bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int CW = $clog2(LAT + 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [31:0]      r_fpu_a, r_fpu_b;
   logic [1:0]       r_fpu_op;
   logic [TAG_W-1:0] r_tag;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_data;
   logic [1:0]       r_rsp_op;
   logic [TAG_W-1:0] r_rsp_tag;

   fpu_req_t         w_push_req, w_head;
   logic             w_full, w_empty, w_push, w_pop;
   logic             w_unused_tag;

   assign w_push_req = '{a: bus.req_a, b: bus.req_b, op: bus.req_op,
                         tag: TAG_WMAX'(bus.req_tag)};
   // req_ready comes from registered occupancy only, so a pop in the same
   // cycle never opens a slot for a push.
   assign bus.req_ready = !w_full;
   assign w_push        = bus.req_valid && !w_full;
   // Pop from IDLE, or straight from RESP on acceptance (no IDLE bubble).
   assign w_pop = !w_empty &&
                  ((r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready));
   assign w_unused_tag = ^w_head.tag;

   fpu_drv_fifo #(.DEPTH(DEPTH), .W($bits(fpu_req_t))) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_push_req),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_fpu_a     <= '0;
         r_fpu_b     <= '0;
         r_fpu_op    <= '0;
         r_tag       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_op    <= '0;
         r_rsp_tag   <= '0;
      end else begin
         // Operand load happens only on a pop; fpu_* hold otherwise.
         if (w_pop) begin
            r_fpu_a  <= w_head.a;
            r_fpu_b  <= w_head.b;
            r_fpu_op <= w_head.op;
            r_tag    <= w_head.tag[TAG_W-1:0];
            r_cnt    <= '0;
         end
         case (r_state)
            IDLE: if (!w_empty) r_state <= EXEC;
            EXEC: begin
               if (r_cnt == CW'(LAT)) begin
                  r_rsp_data  <= bus.fpu_outp;
                  r_rsp_op    <= r_fpu_op;
                  r_rsp_tag   <= r_tag;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= w_empty ? IDLE : EXEC;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef FPU_DRV_CLASS_EN
   logic [2:0] r_class;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       r_class <= '0;
      else if ((r_state == EXEC) && (r_cnt == CW'(LAT))) r_class <= f_class(bus.fpu_outp);
   end
   assign bus.rsp_class = r_class;
`endif

   assign bus.fpu_a      = r_fpu_a;
   assign bus.fpu_b      = r_fpu_b;
   assign bus.fpu_opcode = r_fpu_op;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_op     = r_rsp_op;
   assign bus.rsp_tag    = r_rsp_tag;
   assign busy           = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_fpu_driver.sv
// tb_fpu_driver: directed bench for fpu_driver (DEPTH=4, LAT=1).
// The FPU model is a registered lookup of hand-computed IEEE-754 results.
import fpu_drv_pkg::*;

module tb_fpu_driver;
   localparam int DEPTH = 4;
   localparam int LAT   = 1;
   localparam int TAG_W = 4;
   localparam int NV    = 10;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   busy;
   logic [$clog2(DEPTH):0] count;

   fpu_driver_if #(.TAG_W(TAG_W)) bus();

   fpu_driver #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .count (count)
   );

   always #5 clk = ~clk;

   // 1+2=3, 3-1=2, 1/2=0.5, 2*2=4, 2+2=4, 4-2=2, 0/0=NaN, 1/0=inf, 0*1=0, 1*1=1
   logic [31:0] VA [NV] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h40000000,
                            32'h40800000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000};
   logic [31:0] VB [NV] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                            32'h40000000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000};
   logic [1:0]  VO [NV] = '{OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_ADD, OP_SUB, OP_DIV, OP_DIV, OP_MUL, OP_MUL};
   logic [31:0] VR [NV] = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40800000, 32'h40800000,
                            32'h40000000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h3F800000};
   logic [2:0]  VC [NV] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                            3'b000, 3'b100, 3'b010, 3'b001, 3'b000};

   function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      for (int i = 0; i < NV; i++)
         if (VA[i] == a && VB[i] == b && VO[i] == op) return VR[i];
      return 32'hDEADBEEF;
   endfunction

   // One-edge registered FPU (LAT = 1).
   always @(posedge clk) bus.fpu_outp <= fpu_ref(bus.fpu_a, bus.fpu_b, bus.fpu_opcode);

   typedef struct { int idx; logic [TAG_W-1:0] tag; } exp_t;
   exp_t exp_q[$];

   int n_chk = 0, n_pass = 0, cyc = 0, last_hs = 0, drv_idx = 0;
   bit gap_en = 1'b0, have_last = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic set_req(input int idx, input logic [TAG_W-1:0] tag);
      drv_idx       = idx;
      bus.req_a     = VA[idx];
      bus.req_b     = VB[idx];
      bus.req_op    = VO[idx];
      bus.req_tag   = tag;
      bus.req_valid = 1'b1;
   endtask

   // Scoreboard the handshakes due at the coming edge, then advance one cycle.
   task automatic tick();
      exp_t e;
      if (bus.req_valid && bus.req_ready) begin
         e.idx = drv_idx; e.tag = bus.req_tag;
         exp_q.push_back(e);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) chk("rsp_unexp", bus.rsp_valid, 0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data, VR[e.idx]);
            chk("rsp_tag", bus.rsp_tag, e.tag);
            chk("rsp_op", bus.rsp_op, VO[e.idx]);
            if (gap_en && have_last) chk("b2b_gap", cyc - last_hs, LAT + 2);
            have_last = 1'b1;
            last_hs   = cyc;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic send_wait(input int idx, input logic [TAG_W-1:0] tag);
      int n;
      set_req(idx, tag);
      n = 0;
      while (!bus.req_ready && n < 50) begin tick(); n++; end
      tick();
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin tick(); n++; end
      chk("rsp_wait", bus.rsp_valid, 1);
`ifdef FPU_DRV_CLASS_EN
      chk("rsp_class", bus.rsp_class, VC[idx]);
`endif
      tick();
   endtask

   initial begin
      int n;
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
      bus.req_op = '0; bus.req_tag = '0; bus.rsp_ready = 1'b1;

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_fpu_a", bus.fpu_a, 0);
      chk("rst_fpu_op", bus.fpu_opcode, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_tag", bus.rsp_tag, 0);
      rst_n = 1'b1;
      tick();

      // Single add: accepted e0, popped e1, rsp_valid from e3
      set_req(0, 4'd5);
      tick();
      bus.req_valid = 1'b0;
      chk("t1_count_e0", count, 1);
      chk("t1_busy_e0", busy, 1);
      tick();
      chk("t1_fpu_a", bus.fpu_a, VA[0]);
      chk("t1_fpu_b", bus.fpu_b, VB[0]);
      chk("t1_fpu_op", bus.fpu_opcode, VO[0]);
      chk("t1_count_e1", count, 0);
      chk("t1_rv_e1", bus.rsp_valid, 0);
      tick();
      chk("t1_rv_e2", bus.rsp_valid, 0);
      tick();
      chk("t1_rv_e3", bus.rsp_valid, 1);
      chk("t1_data_e3", bus.rsp_data, VR[0]);
      chk("t1_tag_e3", bus.rsp_tag, 5);
      tick();
      chk("t1_rv_done", bus.rsp_valid, 0);
      chk("t1_busy_done", busy, 0);
      chk("t1_fpu_a_hold", bus.fpu_a, VA[0]);

      // Burst of 6 with rsp_ready low: 5 accepted, 6th blocked
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_req(i, TAG_W'(i));
         if (i == 5) chk("burst_rdy6", bus.req_ready, 0);
         tick();
      end
      chk("burst_count", count, 4);
      chk("burst_ready", bus.req_ready, 0);

      // Backpressure: response and operands stable for 7 cycles
      for (int i = 0; i < 7; i++) begin
         chk("bp_rv", bus.rsp_valid, 1);
         chk("bp_data", bus.rsp_data, VR[0]);
         chk("bp_tag", bus.rsp_tag, 0);
         chk("bp_fpu_a", bus.fpu_a, VA[0]);
         chk("bp_fpu_op", bus.fpu_opcode, VO[0]);
         tick();
      end

      // Full FIFO: pop with req_valid high -> no push this edge, push next
      bus.rsp_ready = 1'b1;
      gap_en = 1'b1; have_last = 1'b0;
      tick();
      chk("full_pop_count", count, 3);
      chk("full_pop_ready", bus.req_ready, 1);
      chk("full_pop_fpu_a", bus.fpu_a, VA[1]);
      tick();
      bus.req_valid = 1'b0;
      chk("full_push_count", count, 4);
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
      chk("drain_left", exp_q.size(), 0);
      gap_en = 1'b0;
      chk("drain_busy", busy, 0);

      // Async reset during EXEC with 3 queued
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin set_req(i, TAG_W'(8 + i)); tick(); end
      bus.rsp_ready = 1'b1;
      set_req(4, 4'd12);
      tick();
      bus.req_valid = 1'b0;
      chk("pre_rst_count", count, 3);
      chk("pre_rst_rv", bus.rsp_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rv", bus.rsp_valid, 0);
      chk("arst_count", count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", bus.req_ready, 1);
      chk("arst_fpu_a", bus.fpu_a, 0);
      chk("arst_fpu_op", bus.fpu_opcode, 0);
      chk("arst_data", bus.rsp_data, 0);
      chk("arst_tag", bus.rsp_tag, 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("post_rst_rv", bus.rsp_valid, 0);
         chk("post_rst_count", count, 0);
         tick();
      end
      send_wait(9, 4'd13);
      chk("post_rst_left", exp_q.size(), 0);

      // Special values (class check when enabled)
      for (int i = 6; i < 10; i++) send_wait(i, TAG_W'(i));
      chk("final_left", exp_q.size(), 0);
      chk("final_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
